top_module_switch: RTL and testbench

Single-input, four-output packet switch for the mesh NoC. It accepts 32-bit flits from one upstream link using a two-phase req/ack handshake and decodes the destination from the header flit. The whole packet, header through tail, goes to one of four downstream links. The output stays locked until downstream reports that the tail has passed. This is the clocked replacement for the MouseTrap switch element at each router input.

---
 rtl/top_module_switch_pkg.sv | 43 ++++
 rtl/top_module_switch_if.sv | 38 +++
 rtl/top_module_switch_xy_route.sv | 33 +++
 rtl/top_module_switch.sv | 111 +++++++++++
 tb/tb_top_module_switch.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/top_module_switch_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC types, header field offsets and port indices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

  typedef enum logic [1:0] {
    BODY = 2'b00,
    HEAD = 2'b01,
    TAIL = 2'b10
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } switch_state_e;

  localparam int c_coord_w    = 4;
  localparam int c_dest_x_lsb = 9;
  localparam int c_dest_y_lsb = 5;
  localparam int c_loc_lsb    = 2;

  localparam logic [1:0] c_port_e = 2'd0;
  localparam logic [1:0] c_port_w = 2'd1;
  localparam logic [1:0] c_port_n = 2'd2;
  localparam logic [1:0] c_port_s = 2'd3;

  // Encoding 11 is not HEAD or TAIL, so it naturally falls through as body.
  function automatic logic is_head(input logic [1:0] t);
    return t == HEAD;
  endfunction

  function automatic logic is_tail(input logic [1:0] t);
    return t == TAIL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/top_module_switch_if.sv
// ============================================================================
// Module      : top_module_switch_if
// Description : Upstream and per-port downstream link signals of the switch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface top_module_switch_if #(
  parameter int WORD_WIDTH = 32,
  parameter int OUTPORTS   = 4
) ();
  logic                  gen_enable;
  logic                  req_up_i;
  logic [WORD_WIDTH-1:0] Data_up_i;
  logic                  ack_up_o;
  logic [OUTPORTS-1:0]   req_dw_o;
  logic [WORD_WIDTH-1:0] Data_dw0_o;
  logic [WORD_WIDTH-1:0] Data_dw1_o;
  logic [WORD_WIDTH-1:0] Data_dw2_o;
  logic [WORD_WIDTH-1:0] Data_dw3_o;
  logic [OUTPORTS-1:0]   ack_dw_i;
  logic [OUTPORTS-1:0]   Tailpassed_dw_i;
  logic [OUTPORTS-1:0]   PacketEnable_dw_o;

  modport master (
    output gen_enable, req_up_i, Data_up_i, ack_dw_i, Tailpassed_dw_i,
    input  ack_up_o, req_dw_o, Data_dw0_o, Data_dw1_o, Data_dw2_o, Data_dw3_o,
           PacketEnable_dw_o
  );

  modport slave (
    input  gen_enable, req_up_i, Data_up_i, ack_dw_i, Tailpassed_dw_i,
    output ack_up_o, req_dw_o, Data_dw0_o, Data_dw1_o, Data_dw2_o, Data_dw3_o,
           PacketEnable_dw_o
  );
endinterface

`default_nettype wire

// File: rtl/top_module_switch_xy_route.sv
// ============================================================================
// Module      : xy_route
// Description : Combinational XY routing of a header to an output port index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xy_route
  import noc_pkg::*;
#(
  parameter int X_LOC = 2,
  parameter int Y_LOC = 1
) (
  input  wire logic [c_coord_w-1:0] dest_x,
  input  wire logic [c_coord_w-1:0] dest_y,
  input  wire logic [1:0]           loc,
  output logic      [1:0]           port
);

  localparam logic [c_coord_w-1:0] c_x = c_coord_w'(X_LOC);
  localparam logic [c_coord_w-1:0] c_y = c_coord_w'(Y_LOC);

  always_comb begin
    port = loc;
    if (dest_x > c_x)      port = c_port_e;
    else if (dest_x < c_x) port = c_port_w;
    else if (dest_y > c_y) port = c_port_n;
    else if (dest_y < c_y) port = c_port_s;
  end

endmodule

`default_nettype wire

// File: rtl/top_module_switch.sv
// ============================================================================
// Module      : top_module_switch
// Description : 1-in/4-out two-phase packet switch, one flit holding register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_module_switch
  import noc_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int OUTPORTS   = 4,
  parameter int X_LOC      = 2,
  parameter int Y_LOC      = 1
) (
  input wire logic          clk,
  input wire logic          reset,
  top_module_switch_if.slave sw
);

  switch_state_e         r_state;
  logic [1:0]            r_port;
  logic                  r_hold_valid;
  logic [WORD_WIDTH-1:0] r_hold_data;
  logic                  r_ack_up;
  logic [OUTPORTS-1:0]   r_req_dw;
  logic [OUTPORTS-1:0]   r_pkt_en;
  logic [WORD_WIDTH-1:0] r_data_dw [OUTPORTS];

  logic [1:0]            w_route_port;
  logic [OUTPORTS-1:0]   w_route_onehot;
  logic                  w_accept;
  logic                  w_port_idle;
  logic                  w_forward;
  logic                  w_release;

  xy_route #(
    .X_LOC (X_LOC),
    .Y_LOC (Y_LOC)
  ) u_xy_route (
    .dest_x (sw.Data_up_i[c_dest_x_lsb +: c_coord_w]),
    .dest_y (sw.Data_up_i[c_dest_y_lsb +: c_coord_w]),
    .loc    (sw.Data_up_i[c_loc_lsb +: 2]),
    .port   (w_route_port)
  );

  assign w_route_onehot = {{(OUTPORTS-1){1'b0}}, 1'b1} << w_route_port;
  assign w_accept    = sw.gen_enable && (sw.req_up_i != r_ack_up)
                       && !r_hold_valid && (r_state != DRAIN);
  assign w_port_idle = (sw.ack_dw_i[r_port] == r_req_dw[r_port]);
  assign w_forward   = r_hold_valid && w_port_idle;
  // The holding register must also be empty so a stale Tailpassed cannot
  // release the port before the tail has actually been sent downstream.
  assign w_release   = (r_state == DRAIN) && !r_hold_valid && w_port_idle
                       && sw.Tailpassed_dw_i[r_port];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_port       <= 2'd0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_ack_up     <= 1'b0;
      r_req_dw     <= '0;
      r_pkt_en     <= '0;
      for (int i = 0; i < OUTPORTS; i++) r_data_dw[i] <= '0;
    end else begin
      if (w_forward) begin
        r_req_dw[r_port]  <= ~r_req_dw[r_port];
        r_data_dw[r_port] <= r_hold_data;
        r_hold_valid      <= 1'b0;
      end
      if (w_accept) begin
        r_ack_up <= sw.req_up_i;
        case (r_state)
          IDLE: begin
            // Non-head flits arriving outside a packet are acked and dropped.
            if (is_head(sw.Data_up_i[1:0])) begin
              r_hold_valid <= 1'b1;
              r_hold_data  <= sw.Data_up_i;
              r_port       <= w_route_port;
              r_pkt_en     <= w_route_onehot;
              r_state      <= BUSY;
            end
          end
          BUSY: begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= sw.Data_up_i;
            if (is_tail(sw.Data_up_i[1:0])) r_state <= DRAIN;
          end
          default: ;
        endcase
      end
      if (w_release) begin
        r_pkt_en <= '0;
        r_state  <= IDLE;
      end
    end
  end

  assign sw.ack_up_o          = r_ack_up;
  assign sw.req_dw_o          = r_req_dw;
  assign sw.PacketEnable_dw_o = r_pkt_en;
  assign sw.Data_dw0_o        = r_data_dw[0];
  assign sw.Data_dw1_o        = r_data_dw[1];
  assign sw.Data_dw2_o        = r_data_dw[2];
  assign sw.Data_dw3_o        = r_data_dw[3];

endmodule

`default_nettype wire

// File: tb/tb_top_module_switch.sv
// ============================================================================
// Module      : tb_top_module_switch
// Description : Directed, table-driven self-checking bench for the switch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_module_switch;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  top_module_switch_if #(.WORD_WIDTH(32), .OUTPORTS(4)) sw ();

  top_module_switch #(
    .WORD_WIDTH (32),
    .OUTPORTS   (4),
    .X_LOC      (2),
    .Y_LOC      (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          port;
    logic [3:0]  pe;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] dw(input int p);
    case (p)
      0:       return sw.Data_dw0_o;
      1:       return sw.Data_dw1_o;
      2:       return sw.Data_dw2_o;
      default: return sw.Data_dw3_o;
    endcase
  endfunction

  // Send one flit with the target port idle: accept at the next edge,
  // forward at the edge after, then the downstream acks.
  task automatic send_fwd(input vec_t v, input string tag);
    @(negedge clk);
    sw.Data_up_i = v.data;
    sw.req_up_i  = ~sw.req_up_i;
    @(posedge clk); #1;
    check({tag, "_accept"}, 32'(sw.ack_up_o), 32'(sw.req_up_i));
    check({tag, "_pe"}, 32'(sw.PacketEnable_dw_o), 32'(v.pe));
    @(posedge clk); #1;
    check({tag, "_fwd_req"}, 32'(sw.req_dw_o[v.port] ^ sw.ack_dw_i[v.port]), 32'd1);
    check({tag, "_fwd_data"}, dw(v.port), v.data);
    @(negedge clk);
    sw.ack_dw_i[v.port] = sw.req_dw_o[v.port];
  endtask

  task automatic send_up(input logic [31:0] data, input string tag);
    int n = 0;
    while (sw.ack_up_o != sw.req_up_i && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_up_timeout"}, 32'(n < 20), 32'd1);
    @(negedge clk);
    sw.Data_up_i = data;
    sw.req_up_i  = ~sw.req_up_i;
  endtask

  task automatic recv(input int p, input logic [31:0] exp, input string tag);
    int n = 0;
    while (sw.req_dw_o[p] == sw.ack_dw_i[p] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_dw_timeout"}, 32'(n < 20), 32'd1);
    check({tag, "_dw_data"}, dw(p), exp);
    @(negedge clk);
    sw.ack_dw_i[p] = sw.req_dw_o[p];
  endtask

  task automatic release_port(input int p, input string tag);
    @(negedge clk);
    sw.Tailpassed_dw_i[p] = 1'b1;
    @(posedge clk); #1;
    check({tag, "_release"}, 32'(sw.PacketEnable_dw_o), 32'd0);
    @(negedge clk);
    sw.Tailpassed_dw_i[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        pkt1 [4];
    vec_t        pkt2 [4];
    logic [31:0] d3_save;
    logic        r3_save;
    logic [3:0]  req_save;

    n_total = 0;
    n_pass  = 0;

    // Head (x=2,y=0,loc=0) -> south port 3.
    pkt1[0] = '{32'h0000_0401, 3, 4'b1000};
    pkt1[1] = '{32'h0000_0000, 3, 4'b1000};
    pkt1[2] = '{32'hFFFF_FFFC, 3, 4'b1000};
    pkt1[3] = '{32'h0000_0002, 3, 4'b1000};
    // Head (x=2,y=3) -> north port 2.
    pkt2[0] = '{32'h0000_0461, 2, 4'b0100};
    pkt2[1] = '{32'h1111_1110, 2, 4'b0100};
    pkt2[2] = '{32'hABCD_EF00, 2, 4'b0100};
    pkt2[3] = '{32'h1234_5672, 2, 4'b0100};

    reset              = 1'b0;
    sw.gen_enable      = 1'b1;
    sw.req_up_i        = 1'b0;
    sw.Data_up_i       = '0;
    sw.ack_dw_i        = '0;
    sw.Tailpassed_dw_i = '0;

    // A pending request during reset must never be acked.
    #50;
    sw.Data_up_i = 32'h0000_0401;
    sw.req_up_i  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("rst_ack_low", 32'(sw.ack_up_o), 32'd0);
    end
    #5;
    sw.req_up_i = 1'b0;
    #10;
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_dw", 32'(sw.req_dw_o), 32'd0);
    check("rst_pe", 32'(sw.PacketEnable_dw_o), 32'd0);
    check("rst_ack", 32'(sw.ack_up_o), 32'd0);
    for (int p = 0; p < 4; p++) check("rst_data", dw(p), 32'd0);

    for (int i = 0; i < 4; i++) send_fwd(pkt1[i], "pkt1");

    // Port stays locked until downstream reports the tail has passed.
    repeat (3) @(posedge clk);
    #1;
    check("drain_hold_pe", 32'(sw.PacketEnable_dw_o), 32'h8);
    release_port(3, "pkt1");

    // Body flit with no packet open: acked, dropped, nothing forwarded.
    req_save = sw.req_dw_o;
    @(negedge clk);
    sw.Data_up_i = 32'h0000_0010;
    sw.req_up_i  = ~sw.req_up_i;
    @(posedge clk); #1;
    check("drop_ack", 32'(sw.ack_up_o), 32'(sw.req_up_i));
    repeat (2) @(posedge clk);
    #1;
    check("drop_req_dw", 32'(sw.req_dw_o), 32'(req_save));
    check("drop_pe", 32'(sw.PacketEnable_dw_o), 32'd0);

    d3_save = sw.Data_dw3_o;
    r3_save = sw.req_dw_o[3];
    for (int i = 0; i < 4; i++) send_fwd(pkt2[i], "pkt2");
    check("pkt2_p3_data", sw.Data_dw3_o, 32'h0000_0002);
    check("pkt2_p3_data_kept", sw.Data_dw3_o, d3_save);
    check("pkt2_p3_req_kept", 32'(sw.req_dw_o[3]), 32'(r3_save));
    release_port(2, "pkt2");

    // Backpressure on east port 0 (head x=3).
    send_fwd('{32'h0000_0601, 0, 4'b0001}, "bp_head");
    @(negedge clk);
    sw.Data_up_i = 32'h0000_AAA0;
    sw.req_up_i  = ~sw.req_up_i;
    @(posedge clk); #1;
    check("bp_a_accept", 32'(sw.ack_up_o), 32'(sw.req_up_i));
    @(posedge clk); #1;
    check("bp_a_fwd", dw(0), 32'h0000_AAA0);
    @(negedge clk);
    sw.Data_up_i = 32'h0000_BBB0;
    sw.req_up_i  = ~sw.req_up_i;
    @(posedge clk); #1;
    check("bp_b_accept", 32'(sw.ack_up_o), 32'(sw.req_up_i));
    @(negedge clk);
    sw.Data_up_i = 32'h0000_CCC0;
    sw.req_up_i  = ~sw.req_up_i;
    repeat (10) @(posedge clk);
    #1;
    check("bp_stall", 32'(sw.ack_up_o ^ sw.req_up_i), 32'd1);
    check("bp_dw_pending", 32'(sw.req_dw_o[0] ^ sw.ack_dw_i[0]), 32'd1);
    check("bp_dw_hold_a", dw(0), 32'h0000_AAA0);
    @(negedge clk);
    sw.ack_dw_i[0] = sw.req_dw_o[0];
    recv(0, 32'h0000_BBB0, "bp_b");
    recv(0, 32'h0000_CCC0, "bp_c");
    send_up(32'h0000_DDD2, "bp_tail");
    recv(0, 32'h0000_DDD2, "bp_tail");
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_dup", 32'(sw.req_dw_o[0] ^ sw.ack_dw_i[0]), 32'd0);
    check("bp_up_idle", 32'(sw.ack_up_o ^ sw.req_up_i), 32'd0);
    release_port(0, "bp");

    // gen_enable low blocks accepts but not forwarding of a held flit.
    @(negedge clk);
    sw.gen_enable = 1'b0;
    sw.Data_up_i  = 32'h0000_0201;
    sw.req_up_i   = ~sw.req_up_i;
    repeat (5) @(posedge clk);
    #1;
    check("gen_blocked", 32'(sw.ack_up_o ^ sw.req_up_i), 32'd1);
    check("gen_blocked_pe", 32'(sw.PacketEnable_dw_o), 32'd0);
    @(negedge clk);
    sw.gen_enable = 1'b1;
    @(posedge clk); #1;
    check("gen_accept", 32'(sw.ack_up_o), 32'(sw.req_up_i));
    check("gen_pe", 32'(sw.PacketEnable_dw_o), 32'h2);
    @(negedge clk);
    sw.gen_enable = 1'b0;
    recv(1, 32'h0000_0201, "gen_head");
    @(negedge clk);
    sw.gen_enable = 1'b1;
    send_up(32'h0000_0002, "gen_tail");
    recv(1, 32'h0000_0002, "gen_tail");
    release_port(1, "gen");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
